// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative caches: FSM encoding, bus widths
// and field-width derivations from the WAYS/SETS parameters.
package cache_pkg;

  localparam int BLK_W   = 128;
  localparam int WORD_W  = 32;
  localparam int PADDR_W = 30;
  localparam int MADDR_W = 28;

  typedef enum logic [1:0] {
    S_COMPARE    = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_ALLOCATE   = 2'd2
  } state_e;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return MADDR_W - $clog2(sets);
  endfunction

  // Also used as the way-index width; a direct-mapped cache still gets one bit.
  function automatic int age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age bookkeeping per set: age 0 is most recent, WAYS-1 is oldest.
// Victim is the lowest-index invalid way, otherwise the oldest way.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [idx_w(SETS)-1:0]   i_idx,
  input  logic [WAYS-1:0]          i_valid,
  input  logic                     i_touch,
  input  logic [age_w(WAYS)-1:0]   i_touch_way,
  output logic [age_w(WAYS)-1:0]   o_victim
);

  localparam int AGE_W = age_w(WAYS);

  logic [AGE_W-1:0] r_age [SETS][WAYS];
  logic             w_found;
  logic [AGE_W-1:0] w_touch_age;

  assign w_touch_age = r_age[i_idx][i_touch_way];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= AGE_W'(w);
    end else if (i_touch) begin
      // Ages stay a permutation: only ways younger than the touched one move.
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == i_touch_way)
          r_age[i_idx][w] <= '0;
        else if (r_age[i_idx][w] < w_touch_age)
          r_age[i_idx][w] <= r_age[i_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim = AGE_W'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++)
        if (r_age[i_idx][w] == AGE_W'(WAYS - 1))
          o_victim = AGE_W'(w);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache between a 32-bit word
// port and a 128-bit block memory, with saturating hit/miss counters.
module cache_nway
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               proc_reset,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [29:0]        proc_addr,
  output logic [31:0]        proc_rdata,
  input  logic [31:0]        proc_wdata,
  output logic               proc_stall,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_addr,
  input  logic [127:0]       mem_rdata,
  output logic [127:0]       mem_wdata,
  input  logic               mem_ready,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(SETS);
  localparam int WAY_W = age_w(WAYS);

  logic [WAYS-1:0]   r_valid [SETS];
  logic [WAYS-1:0]   r_dirty [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  logic [BLK_W-1:0]  r_data  [SETS][WAYS];

  state_e            r_state;
  state_e            w_next;
  logic [WAY_W-1:0]  r_victim;
  logic              r_replay;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [1:0]        w_off;
  logic              w_req;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic [WAY_W-1:0]  w_victim;
  logic              w_touch;
  logic [BLK_W-1:0]  w_blk;
  logic [BLK_W-1:0]  w_wblk;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [27:0]       w_mem_addr;
  logic [BLK_W-1:0]  w_mem_wdata;

  assign w_idx   = proc_addr[IDX_W+1:2];
  assign w_tag   = proc_addr[29:IDX_W+2];
  assign w_off   = proc_addr[1:0];
  assign w_req   = proc_read | proc_write;
  assign w_touch = (r_state == S_COMPARE) && w_req && w_hit;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_blk = r_data[w_idx][w_hit_way];

  always_comb begin
    w_wblk = w_blk;
    w_wblk[{w_off, 5'b0} +: WORD_W] = proc_wdata;
  end

  cache_lru #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk         (clk),
    .rst         (proc_reset),
    .i_idx       (w_idx),
    .i_valid     (r_valid[w_idx]),
    .i_touch     (w_touch),
    .i_touch_way (w_hit_way),
    .o_victim    (w_victim)
  );

  always_comb begin
    w_next      = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      S_COMPARE: begin
        if (w_req && !w_hit)
          w_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) ?
                   S_WRITE_BACK : S_ALLOCATE;
      end
      S_WRITE_BACK: begin
        w_mem_write = 1'b1;
        w_mem_addr  = {r_tag[w_idx][r_victim], w_idx};
        w_mem_wdata = r_data[w_idx][r_victim];
        if (mem_ready) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        w_mem_read = 1'b1;
        w_mem_addr = proc_addr[29:2];
        if (mem_ready) w_next = S_COMPARE;
      end
      default: w_next = S_COMPARE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state    <= S_COMPARE;
      r_victim   <= '0;
      r_replay   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_COMPARE: begin
          r_replay <= 1'b0;
          if (w_req && w_hit) begin
            // The access replayed after a fill was already counted as a miss.
            if (!r_replay && (r_hit_cnt != {CNT_W{1'b1}}))
              r_hit_cnt <= r_hit_cnt + 1'b1;
            if (proc_write)
              r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else if (w_req) begin
            r_victim <= w_victim;
            if (r_miss_cnt != {CNT_W{1'b1}})
              r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_replay                 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload arrays need no reset; the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (w_touch && proc_write)
      r_data[w_idx][w_hit_way] <= w_wblk;
    if ((r_state == S_ALLOCATE) && mem_ready) begin
      r_data[w_idx][r_victim] <= mem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end

  assign proc_stall = (r_state != S_COMPARE) || (w_req && !w_hit);
  assign proc_rdata = ((r_state == S_COMPARE) && proc_read && !proc_write && w_hit) ?
                      w_blk[{w_off, 5'b0} +: WORD_W] : '0;
  assign mem_read   = w_mem_read;
  assign mem_write  = w_mem_write;
  assign mem_addr   = w_mem_addr;
  assign mem_wdata  = w_mem_wdata;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
